// File: rtl/imem_access_ctrl_if.sv
// Bundle of fetch, loader and memory-port signals for imem_access_ctrl.
// slave = the controller itself; master = requesters plus the memory macro.
interface imem_access_ctrl_if #(
  parameter int IDX_W = 10
) ();
  logic             f_req;
  logic [31:0]      f_addr;
  logic             f_gnt;
  logic             f_rvalid;
  logic [31:0]      f_rdata;
  logic             f_err;
  logic             l_req;
  logic [31:0]      l_addr;
  logic [31:0]      l_wdata;
  logic             l_gnt;
  logic             init_busy;
  logic             mem_cs;
  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;
  logic             state_dbg;

  // Handshake: a requester raises *_req with stable address/data and holds
  // them until the matching *_gnt is seen high in a cycle; the access is
  // taken at the rising edge closing that cycle. f_rvalid is a one-cycle
  // pulse with no back-pressure, one per fetch grant, in grant order.
  modport slave (
    input  f_req, f_addr, l_req, l_addr, l_wdata, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, f_err, l_gnt, init_busy,
           mem_cs, mem_we, mem_idx, mem_wdata, state_dbg
  );

  modport master (
    output f_req, f_addr, l_req, l_addr, l_wdata, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, f_err, l_gnt, init_busy,
           mem_cs, mem_we, mem_idx, mem_wdata, state_dbg
  );
endinterface

// File: rtl/imem_access_ctrl.sv
// Single-port instruction memory arbiter: core fetch reads vs loader writes.
// Define IMEM_CLEAR_ON_RESET_EN to zero-fill the memory after every reset.
module imem_access_ctrl #(
  parameter int DEPTH    = 1024,
  parameter int IDX_W    = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  imem_access_ctrl_if.slave bus
);

  localparam int          WCNT_W  = $clog2(MAX_WAIT + 1);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

`ifdef IMEM_CLEAR_ON_RESET_EN
  localparam state_e RESET_STATE = ST_INIT;
`else
  localparam state_e RESET_STATE = ST_RUN;
`endif

  state_e            state_q;
  logic [IDX_W-1:0]  init_idx_q;
  logic [WCNT_W-1:0] wait_cnt_q;
  logic              rvalid_q;
  logic              err_q;
  logic [31:0]       rdata_q;

  logic run_act;
  logic init_act;
  logic loader_turn;
  logic f_gnt;
  logic l_gnt;
  logic f_bad;
  logic l_oor;

  // Gated by reset so the memory port and grants sit idle while reset is held.
  assign run_act     = (state_q == ST_RUN)  && !reset;
  assign init_act    = (state_q == ST_INIT) && !reset;
  assign loader_turn = (wait_cnt_q == WCNT_W'(MAX_WAIT));

  assign f_gnt = run_act && bus.f_req && !(bus.l_req && loader_turn);
  assign l_gnt = run_act && bus.l_req && (!bus.f_req || loader_turn);

  assign f_bad = (bus.f_addr[1:0] != 2'b00) || (bus.f_addr[31:2] >= DEPTH_W);
  assign l_oor = (bus.l_addr[31:2] >= DEPTH_W);

  always_comb begin
    bus.mem_cs    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_idx   = '0;
    bus.mem_wdata = '0;
    if (init_act) begin
      bus.mem_cs  = 1'b1;
      bus.mem_we  = 1'b1;
      bus.mem_idx = init_idx_q;
    end else if (f_gnt && !f_bad) begin
      bus.mem_cs  = 1'b1;
      bus.mem_idx = bus.f_addr[IDX_W+1:2];
    end else if (l_gnt && !l_oor) begin
      bus.mem_cs    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_idx   = bus.l_addr[IDX_W+1:2];
      bus.mem_wdata = bus.l_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RESET_STATE;
      init_idx_q <= '0;
      wait_cnt_q <= '0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rvalid_q <= f_gnt;
      err_q    <= f_gnt && f_bad;
      if (f_gnt) begin
        rdata_q <= f_bad ? 32'h0 : bus.mem_rdata;
      end

      case (state_q)
        ST_INIT: begin
          init_idx_q <= init_idx_q + 1'b1;
          if (init_idx_q == IDX_W'(DEPTH - 1)) begin
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_RUN;
      endcase

      // Counts fetch wins against a waiting loader; saturation hands it the port.
      if (l_gnt || !bus.l_req) begin
        wait_cnt_q <= '0;
      end else if (f_gnt && !loader_turn) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
    end
  end

  assign bus.f_gnt    = f_gnt;
  assign bus.l_gnt    = l_gnt;
  assign bus.f_rvalid = rvalid_q;
  assign bus.f_err    = err_q;
  assign bus.f_rdata  = rdata_q;
  assign bus.state_dbg = state_q;

`ifdef IMEM_CLEAR_ON_RESET_EN
  assign bus.init_busy = (state_q == ST_INIT);
`else
  assign bus.init_busy = 1'b0;
`endif

endmodule
